// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle data-memory responder. It holds the MEM stage with
//            stall for a fixed latency, then completes a store or load.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int LATENCY     = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [3:0]             wstrb,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ack,
    output logic                   stall,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    state_t                   r_state;
    logic [3:0]               r_cnt;
    logic                     r_we;
    logic [ADDR_W-1:0]        r_addr;
    logic [DATA_W-1:0]        r_wdata;
    logic [3:0]               r_wstrb;
    logic [DATA_W-1:0]        r_rdata;
    logic [STALL_CNT_W-1:0]   r_stall_cycles;
    logic [DATA_W-1:0]        r_mem [0:(1<<ADDR_W)-1];

    logic                     w_stall;
    logic                     w_access;
    logic                     w_mem_we;

    assign w_stall  = ((r_state == S_IDLE) && req) || (r_state == S_WAIT);
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // Reset wins over a store landing on the same edge
    assign w_mem_we = !rst && w_access && r_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= 4'd0;
            r_rdata        <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            r_rdata <= r_mem[r_addr];
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) begin
                    r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata        = r_rdata;
    assign ack          = (r_state == S_RESP);
    assign stall        = w_stall;
    assign busy         = (r_state != S_IDLE);
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
